// File: rtl/adder_checker.sv
// -----------------------------------------------------------------------------
// adder_checker
//
// Response monitor for a width-parameterised adder under test. Every accepted
// operand vector gets a golden {cout,sum} that is carried down a delay line of
// LATENCY stages. When it reaches the end of the line it is compared with the
// adder's actual result. The checker counts the vectors it compared and the
// mismatches it found, keeps the first failing vector, and reports completion
// with a pass/fail flag.
//
// Parameters
//   width        operand / sum width in bits
//   LATENCY      adder result delay in clock cycles (0 = combinational adder)
//   STOP_ON_ERR  1: finish the run on the first mismatch
//
// Ports
//   i_clk           rising-edge clock
//   i_rst           synchronous reset, active-high
//   i_start         one-cycle pulse: clear statistics and begin a run
//   i_in_valid      i_a / i_b / i_cin carry a vector this cycle
//   i_in_last       together with i_in_valid: final vector of the run
//   i_a, i_b        operands applied to the adder
//   i_cin           carry-in applied to the adder
//   i_sum, i_cout   adder result, LATENCY cycles after its operands
//   o_busy          run in progress (RUN or DRAIN)
//   o_done          run finished, held until start or reset
//   o_pass          done with no mismatches
//   o_chk_count     vectors compared (saturating)
//   o_err_count     mismatches found (saturating)
//   o_fail_valid    a failing vector has been captured
//   o_fail_a/_b     operands of the first mismatch
//   o_fail_cin      carry-in of the first mismatch
//   o_fail_got      adder {cout,sum} of the first mismatch
//   o_fail_exp      golden {cout,sum} of the first mismatch
// -----------------------------------------------------------------------------
module adder_checker #(
    parameter int width       = 8,
    parameter int LATENCY     = 0,
    parameter bit STOP_ON_ERR = 1'b0
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_start,
    input  logic               i_in_valid,
    input  logic               i_in_last,
    input  logic [width-1:0]   i_a,
    input  logic [width-1:0]   i_b,
    input  logic               i_cin,
    input  logic [width-1:0]   i_sum,
    input  logic               i_cout,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_pass,
    output logic [2*width:0]   o_chk_count,
    output logic [2*width:0]   o_err_count,
    output logic               o_fail_valid,
    output logic [width-1:0]   o_fail_a,
    output logic [width-1:0]   o_fail_b,
    output logic               o_fail_cin,
    output logic [width:0]     o_fail_got,
    output logic [width:0]     o_fail_exp
);

    localparam int CNT_W   = 2*width + 1;
    // Delay-line entry layout: {last, cin, a, b, exp}
    localparam int ENTRY_W = 3*width + 3;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } stateT;

    stateT              r_state;
    logic               r_busy;
    logic               r_done;
    logic [CNT_W-1:0]   r_chkCount;
    logic [CNT_W-1:0]   r_errCount;
    logic               r_failValid;
    logic [width-1:0]   r_failA;
    logic [width-1:0]   r_failB;
    logic               r_failCin;
    logic [width:0]     r_failGot;
    logic [width:0]     r_failExp;

    logic               w_accept;
    logic               w_startOk;
    logic [width:0]     w_exp;
    logic [ENTRY_W-1:0] w_entry;
    logic               w_stageValid;
    logic [ENTRY_W-1:0] w_stageEntry;
    logic               w_cmpValid;
    logic               w_cmpLast;
    logic               w_cmpCin;
    logic [width-1:0]   w_cmpA;
    logic [width-1:0]   w_cmpB;
    logic [width:0]     w_cmpExp;
    logic [width:0]     w_got;
    logic               w_mismatch;

    // Vectors are only taken while a run is active; a start cycle is never RUN,
    // so a vector presented alongside the start pulse is dropped.
    assign w_accept  = (r_state == RUN) && i_in_valid;
    assign w_startOk = i_start && ((r_state == IDLE) || (r_state == DONE));

    // Golden result is one bit wider than the operands so the carry is kept.
    assign w_exp   = {1'b0, i_a} + {1'b0, i_b} + {{width{1'b0}}, i_cin};
    assign w_entry = {i_in_last, i_cin, i_a, i_b, w_exp};

    generate
        if (LATENCY == 0) begin : g_noDelay
            // Combinational adder: its result belongs to the vector on the inputs now.
            assign w_stageValid = w_accept;
            assign w_stageEntry = w_entry;
        end else begin : g_delayLine
            logic [LATENCY-1:0] r_pipeValid;
            logic [ENTRY_W-1:0] r_pipeData [LATENCY];

            // Valid bits are flushed on reset and at the start of a new run so that
            // leftovers from an aborted run can never be compared.
            always_ff @(posedge i_clk) begin
                if (i_rst || w_startOk) begin
                    r_pipeValid <= '0;
                end else begin
                    r_pipeValid[0] <= w_accept;
                    for (int i = 1; i < LATENCY; i++) begin
                        r_pipeValid[i] <= r_pipeValid[i-1];
                    end
                end
            end

            // Payload follows the valid bits; it is only looked at when valid.
            always_ff @(posedge i_clk) begin
                r_pipeData[0] <= w_entry;
                for (int i = 1; i < LATENCY; i++) begin
                    r_pipeData[i] <= r_pipeData[i-1];
                end
            end

            assign w_stageValid = r_pipeValid[LATENCY-1];
            assign w_stageEntry = r_pipeData[LATENCY-1];
        end
    endgenerate

    assign w_cmpLast = w_stageEntry[ENTRY_W-1];
    assign w_cmpCin  = w_stageEntry[ENTRY_W-2];
    assign w_cmpA    = w_stageEntry[3*width:2*width+1];
    assign w_cmpB    = w_stageEntry[2*width:width+1];
    assign w_cmpExp  = w_stageEntry[width:0];

    // Once a run has stopped early, entries still in flight are not compared.
    assign w_cmpValid = w_stageValid && ((r_state == RUN) || (r_state == DRAIN));
    assign w_got      = {i_cout, i_sum};
    assign w_mismatch = w_cmpValid && (w_got != w_cmpExp);

    // Run control, statistics and first-failure capture. The compare result is
    // registered here, so counters move on the edge that ends the compare cycle
    // and done appears the cycle after the final entry is compared.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= IDLE;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_chkCount  <= '0;
            r_errCount  <= '0;
            r_failValid <= 1'b0;
            r_failA     <= '0;
            r_failB     <= '0;
            r_failCin   <= 1'b0;
            r_failGot   <= '0;
            r_failExp   <= '0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (i_start) begin
                        r_state     <= RUN;
                        r_busy      <= 1'b1;
                        r_done      <= 1'b0;
                        r_chkCount  <= '0;
                        r_errCount  <= '0;
                        r_failValid <= 1'b0;
                        r_failA     <= '0;
                        r_failB     <= '0;
                        r_failCin   <= 1'b0;
                        r_failGot   <= '0;
                        r_failExp   <= '0;
                    end
                end
                RUN, DRAIN: begin
                    if (w_cmpValid) begin
                        if (r_chkCount != '1) begin
                            r_chkCount <= r_chkCount + CNT_W'(1);
                        end
                        if (w_mismatch && (r_errCount != '1)) begin
                            r_errCount <= r_errCount + CNT_W'(1);
                        end
                        if (w_mismatch && !r_failValid) begin
                            r_failValid <= 1'b1;
                            r_failA     <= w_cmpA;
                            r_failB     <= w_cmpB;
                            r_failCin   <= w_cmpCin;
                            r_failGot   <= w_got;
                            r_failExp   <= w_cmpExp;
                        end
                    end
                    // With no delay line the last entry is compared in its own
                    // acceptance cycle, so RUN can go straight to DONE.
                    if ((STOP_ON_ERR && w_mismatch) || (w_cmpValid && w_cmpLast)) begin
                        r_state <= DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else if ((r_state == RUN) && w_accept && i_in_last) begin
                        r_state <= DRAIN;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign o_busy       = r_busy;
    assign o_done       = r_done;
    assign o_pass       = r_done && (r_errCount == '0);
    assign o_chk_count  = r_chkCount;
    assign o_err_count  = r_errCount;
    assign o_fail_valid = r_failValid;
    assign o_fail_a     = r_failA;
    assign o_fail_b     = r_failB;
    assign o_fail_cin   = r_failCin;
    assign o_fail_got   = r_failGot;
    assign o_fail_exp   = r_failExp;

endmodule

// File: tb/tb_adder_checker.sv
// -----------------------------------------------------------------------------
// tb_adder_checker
//
// Drives two checkers from one shared vector stream: dutA watches a
// combinational adder (LATENCY=0, runs to in_last), dutB watches a three-stage
// pipelined adder (LATENCY=3, stops on the first error). Both adders can have
// faults switched in. A run-level reference model predicts the statistics and
// first failure of each checker from plain arithmetic on the vectors sent.
// -----------------------------------------------------------------------------
module tb_adder_checker;

    localparam int W = 8;

    logic           clock = 1'b0;
    logic           reset;
    logic           start;
    logic           inValid;
    logic           inLast;
    logic [W-1:0]   opA;
    logic [W-1:0]   opB;
    logic           carryIn;

    int             faultA;
    int             faultB;
    logic           bShortDelay;

    logic [W-1:0]   aSum;
    logic           aCout;
    logic [W-1:0]   bSum;
    logic           bCout;
    logic [W:0]     bPipe [3];

    logic           aBusy, aDone, aPass, aFailValid, aFailCin;
    logic [2*W:0]   aChk, aErr;
    logic [W-1:0]   aFailA, aFailB;
    logic [W:0]     aFailGot, aFailExp;
    logic           bBusy, bDone, bPass, bFailValid, bFailCin;
    logic [2*W:0]   bChk, bErr;
    logic [W-1:0]   bFailA, bFailB;
    logic [W:0]     bFailGot, bFailExp;

    int             checkCount = 0;
    int             errorCount = 0;

    typedef struct {
        bit           run;
        bit           done;
        int           chk;
        int           err;
        bit           failValid;
        logic [W-1:0] fa;
        logic [W-1:0] fb;
        logic         fc;
        logic [W:0]   got;
        logic [W:0]   exp;
    } modelT;

    modelT mA;
    modelT mB;

    always #5 clock = ~clock;

    // Adder under test with selectable faults:
    // 1: 3+5 (cin=0) reports 9, 2: carry-out stuck at 0, 3: sum LSB flipped for A5+5A.
    function automatic logic [W:0] faultyAdd(input logic [W-1:0] x, input logic [W-1:0] y,
                                             input logic c, input int mode);
        int s;
        s = int'(x) + int'(y) + int'(c);
        if (mode == 1 && x == 8'd3 && y == 8'd5) s = 9;
        else if (mode == 2) s = s & 'hFF;
        else if (mode == 3 && x == 8'hA5 && y == 8'h5A) s = s ^ 1;
        return s[W:0];
    endfunction

    // Combinational adder watched by dutA.
    always_comb {aCout, aSum} = faultyAdd(opA, opB, carryIn, faultA);

    // Three-register adder watched by dutB; the short-delay tap emulates a two-cycle adder.
    always @(posedge clock) begin
        bPipe[0] <= faultyAdd(opA, opB, carryIn, faultB);
        bPipe[1] <= bPipe[0];
        bPipe[2] <= bPipe[1];
    end
    assign {bCout, bSum} = bShortDelay ? bPipe[1] : bPipe[2];

    adder_checker #(.width(W), .LATENCY(0), .STOP_ON_ERR(1'b0)) dutA (
        .i_clk(clock), .i_rst(reset), .i_start(start), .i_in_valid(inValid),
        .i_in_last(inLast), .i_a(opA), .i_b(opB), .i_cin(carryIn),
        .i_sum(aSum), .i_cout(aCout),
        .o_busy(aBusy), .o_done(aDone), .o_pass(aPass),
        .o_chk_count(aChk), .o_err_count(aErr), .o_fail_valid(aFailValid),
        .o_fail_a(aFailA), .o_fail_b(aFailB), .o_fail_cin(aFailCin),
        .o_fail_got(aFailGot), .o_fail_exp(aFailExp)
    );

    adder_checker #(.width(W), .LATENCY(3), .STOP_ON_ERR(1'b1)) dutB (
        .i_clk(clock), .i_rst(reset), .i_start(start), .i_in_valid(inValid),
        .i_in_last(inLast), .i_a(opA), .i_b(opB), .i_cin(carryIn),
        .i_sum(bSum), .i_cout(bCout),
        .o_busy(bBusy), .o_done(bDone), .o_pass(bPass),
        .o_chk_count(bChk), .o_err_count(bErr), .o_fail_valid(bFailValid),
        .o_fail_a(bFailA), .o_fail_b(bFailB), .o_fail_cin(bFailCin),
        .o_fail_got(bFailGot), .o_fail_exp(bFailExp)
    );

    function automatic modelT clearedModel();
        modelT m;
        m.run = 1'b0; m.done = 1'b0; m.chk = 0; m.err = 0; m.failValid = 1'b0;
        m.fa = '0; m.fb = '0; m.fc = 1'b0; m.got = '0; m.exp = '0;
        return m;
    endfunction

    // Run-level view of a checker: a start opens a run, every vector inside a run is
    // judged against a+b+cin, the last vector (or first error when stopping) closes it.
    function automatic modelT modelStep(input modelT m, input logic st, input logic v,
                                        input logic l, input logic [W-1:0] x,
                                        input logic [W-1:0] y, input logic c,
                                        input int mode, input bit stopOnErr);
        modelT n;
        int    gold;
        int    got;
        n = m;
        if (st && !n.run) begin
            n = clearedModel();
            n.run = 1'b1;
        end else if (n.run && v) begin
            gold = int'(x) + int'(y) + int'(c);
            got  = int'(faultyAdd(x, y, c, mode));
            n.chk++;
            if (got != gold) begin
                n.err++;
                if (!n.failValid) begin
                    n.failValid = 1'b1;
                    n.fa = x; n.fb = y; n.fc = c;
                    n.got = 9'(got); n.exp = 9'(gold);
                end
                if (stopOnErr) begin
                    n.run = 1'b0;
                    n.done = 1'b1;
                end
            end
            if (l && n.run) begin
                n.run = 1'b0;
                n.done = 1'b1;
            end
        end
        return n;
    endfunction

    // Present one cycle of inputs at the falling edge, update the models, and return
    // at the next falling edge where outputs are stable.
    task automatic applyStimulus(input logic st, input logic v, input logic l,
                                 input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        start = st; inValid = v; inLast = l; opA = x; opB = y; carryIn = c;
        mA = modelStep(mA, st, v, l, x, y, c, faultA, 1'b0);
        mB = modelStep(mB, st, v, l, x, y, c, faultB, 1'b1);
        @(negedge clock);
        start = 1'b0; inValid = 1'b0; inLast = 1'b0;
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
    endtask

    task automatic doReset();
        reset = 1'b1; start = 1'b0; inValid = 1'b0; inLast = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        mA = clearedModel();
        mB = clearedModel();
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) else begin
            errorCount++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic checkDut(input string tag, input modelT m, input logic busy,
                            input logic done, input logic pass, input logic [2*W:0] chk,
                            input logic [2*W:0] err, input logic fv, input logic [W-1:0] fa,
                            input logic [W-1:0] fb, input logic fc, input logic [W:0] got,
                            input logic [W:0] exp);
        checkOutput({tag, "_chk"}, 32'(chk), m.chk);
        checkOutput({tag, "_err"}, 32'(err), m.err);
        checkOutput({tag, "_busy"}, 32'(busy), 32'(m.run));
        checkOutput({tag, "_done"}, 32'(done), 32'(m.done));
        checkOutput({tag, "_pass"}, 32'(pass), 32'(m.done && m.err == 0));
        checkOutput({tag, "_failValid"}, 32'(fv), 32'(m.failValid));
        checkOutput({tag, "_failA"}, 32'(fa), 32'(m.fa));
        checkOutput({tag, "_failB"}, 32'(fb), 32'(m.fb));
        checkOutput({tag, "_failCin"}, 32'(fc), 32'(m.fc));
        checkOutput({tag, "_failGot"}, 32'(got), 32'(m.got));
        checkOutput({tag, "_failExp"}, 32'(exp), 32'(m.exp));
    endtask

    task automatic checkA(input string tag);
        checkDut({tag, "_A"}, mA, aBusy, aDone, aPass, aChk, aErr, aFailValid,
                 aFailA, aFailB, aFailCin, aFailGot, aFailExp);
    endtask

    task automatic checkB(input string tag);
        checkDut({tag, "_B"}, mB, bBusy, bDone, bPass, bChk, bErr, bFailValid,
                 bFailA, bFailB, bFailCin, bFailGot, bFailExp);
    endtask

    initial begin
        faultA = 0; faultB = 0; bShortDelay = 1'b0;
        opA = '0; opB = '0; carryIn = 1'b0;
        doReset();
        doReset();
        checkA("reset");
        checkB("reset");

        // Full sweep of a,b with cin=0.
        applyStimulus(1'b1, 1'b0, 1'b0, '0, '0, 1'b0);
        for (int i = 0; i < 65536; i++) begin
            applyStimulus(1'b0, 1'b1, (i == 65535), 8'(i >> 8), 8'(i & 255), 1'b0);
        end
        checkA("sweep");
        checkOutput("sweep_chk65536_A", 32'(aChk), 32'd65536);
        checkOutput("sweep_pass_A", 32'(aPass), 32'd1);
        idleCycles(2);
        checkOutput("sweep_doneNotYet_B", 32'(bDone), 32'd0);
        idleCycles(1);
        checkB("sweep");
        // Vectors after done are ignored.
        applyStimulus(1'b0, 1'b1, 1'b1, 8'd1, 8'd1, 1'b0);
        checkA("afterDone");

        // Sum forced wrong for 3+5; the start-cycle vector must be dropped.
        faultA = 1;
        applyStimulus(1'b1, 1'b1, 1'b0, 8'd3, 8'd5, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'd1, 8'd1, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'd3, 8'd5, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'd3, 8'd5, 1'b1);
        // A start inside a run is ignored.
        applyStimulus(1'b1, 1'b0, 1'b0, '0, '0, 1'b0);
        checkA("midRun");
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 8'($urandom_range(8, 255)), 8'($urandom),
                          1'($urandom));
        end
        applyStimulus(1'b0, 1'b1, 1'b1, 8'd7, 8'd9, 1'b0);
        checkA("sumFault");
        checkOutput("sumFault_got9_A", 32'(aFailGot), 32'd9);
        checkOutput("sumFault_exp8_A", 32'(aFailExp), 32'd8);
        checkOutput("sumFault_err1_A", 32'(aErr), 32'd1);
        idleCycles(4);
        checkB("sumFault");

        // Carry-out stuck at 0: first failure 255+255+1, a later one only counts.
        faultA = 2;
        applyStimulus(1'b1, 1'b0, 1'b0, '0, '0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'd1, 8'd2, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'd10, 8'd20, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'd255, 8'd255, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b1, 8'd200, 8'd100, 1'b0);
        checkA("coutFault");
        checkOutput("coutFault_exp1FF_A", 32'(aFailExp), 32'h1FF);
        checkOutput("coutFault_got0FF_A", 32'(aFailGot), 32'h0FF);
        idleCycles(4);
        checkB("coutFault");

        // Random vectors through the aligned three-stage adder.
        faultA = 0;
        applyStimulus(1'b1, 1'b0, 1'b0, '0, '0, 1'b0);
        for (int i = 0; i < 100; i++) begin
            applyStimulus(1'b0, 1'b1, (i == 99), 8'($urandom), 8'($urandom), 1'($urandom));
        end
        idleCycles(4);
        checkA("random");
        checkB("random");
        checkOutput("random_chk100_B", 32'(bChk), 32'd100);

        // Same traffic with a two-cycle adder: the checker must notice.
        bShortDelay = 1'b1;
        applyStimulus(1'b1, 1'b0, 1'b0, '0, '0, 1'b0);
        for (int i = 0; i < 100; i++) begin
            applyStimulus(1'b0, 1'b1, (i == 99), 8'($urandom), 8'($urandom), 1'($urandom));
        end
        idleCycles(4);
        checkOutput("shortDelay_errSeen_B", 32'(bErr != '0), 32'd1);
        checkOutput("shortDelay_failValid_B", 32'(bFailValid), 32'd1);
        checkOutput("shortDelay_done_B", 32'(bDone), 32'd1);
        checkOutput("shortDelay_pass_B", 32'(bPass), 32'd0);
        checkA("shortDelay");
        bShortDelay = 1'b0;
        idleCycles(4);

        // Reset in the middle of a run, then a clean run.
        applyStimulus(1'b1, 1'b0, 1'b0, '0, '0, 1'b0);
        for (int i = 0; i < 40; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 8'($urandom), 8'($urandom), 1'($urandom));
        end
        checkOutput("preReset_chk40_A", 32'(aChk), 32'd40);
        doReset();
        checkA("midReset");
        checkB("midReset");
        applyStimulus(1'b1, 1'b0, 1'b0, '0, '0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b0, 1'b1, (i == 9), 8'($urandom), 8'($urandom), 1'($urandom));
        end
        idleCycles(4);
        checkA("afterReset");
        checkB("afterReset");

        // Stop-on-error: vector 10 of 20 is corrupted in the pipelined adder.
        faultB = 3;
        applyStimulus(1'b1, 1'b0, 1'b0, '0, '0, 1'b0);
        for (int k = 0; k < 20; k++) begin
            if (k == 9) applyStimulus(1'b0, 1'b1, 1'b0, 8'hA5, 8'h5A, 1'b0);
            else applyStimulus(1'b0, 1'b1, (k == 19), 8'($urandom_range(0, 8'hA4)),
                               8'($urandom), 1'($urandom));
            checkOutput($sformatf("stop_doneTiming_k%0d_B", k), 32'(bDone), 32'(k >= 12));
        end
        idleCycles(4);
        checkB("stop");
        checkOutput("stop_chk10_B", 32'(bChk), 32'd10);
        checkOutput("stop_err1_B", 32'(bErr), 32'd1);
        checkA("stop");
        faultB = 0;

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
